// File: rtl/decoder_onehot_seq_pkg.sv
// Shared encodings for the one-hot decoder sequencer: operating modes and FSM states.
package decoder_onehot_seq_pkg;

   localparam logic [1:0] MODE_DECODE = 2'b00;
   localparam logic [1:0] MODE_ACCUM  = 2'b01;
   localparam logic [1:0] MODE_SCAN   = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/decoder_onehot_seq_onehot_dec.sv
// Combinational index-to-one-hot converter; output bit sel is the only bit set.
module onehot_dec #(
   parameter  int SEL_W = 3,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   output logic [OUT_W-1:0] onehot
);

   assign onehot = OUT_W'(1) << sel;

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered one-hot decoder with DECODE, ACCUM (sticky mask) and SCAN (walking one up to k) modes,
// valid/ready on both sides.
module decoder_onehot_seq
   import decoder_onehot_seq_pkg::*;
#(
   parameter  int SEL_W = 3,
   localparam int OUT_W = 2**SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] in_sel,
   output logic [OUT_W-1:0] out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   state_t           state, state_nxt;
   logic [SEL_W-1:0] scan_cnt, scan_cnt_nxt;
   logic [SEL_W-1:0] scan_last, scan_last_nxt;
   logic [SEL_W-1:0] scan_inc;
   logic [OUT_W-1:0] mask, mask_nxt;
   logic [OUT_W-1:0] out_nxt;
   logic             out_valid_nxt;
   logic [OUT_W-1:0] sel_hot, scan_hot;
   logic             accept, out_xfer;

   onehot_dec #(.SEL_W(SEL_W)) u_sel_dec (
      .sel    (in_sel),
      .onehot (sel_hot)
   );

   // scan_cnt indexes the word on out; decode the next index ahead of the transfer
   assign scan_inc = scan_cnt + SEL_W'(1);

   onehot_dec #(.SEL_W(SEL_W)) u_scan_dec (
      .sel    (scan_inc),
      .onehot (scan_hot)
   );

   assign busy     = (state == SCAN);
   assign in_ready = rst_n & en & ~busy & (~out_valid | out_ready);
   assign accept   = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      state_nxt     = state;
      scan_cnt_nxt  = scan_cnt;
      scan_last_nxt = scan_last;
      out_nxt       = out;
      out_valid_nxt = out_valid;
      mask_nxt      = clr ? '0 : mask;

      if (!en) begin
         state_nxt     = IDLE;
         scan_cnt_nxt  = '0;
         out_nxt       = '0;
         out_valid_nxt = 1'b0;
      end else if (state == SCAN) begin
         if (out_xfer) begin
            if (scan_cnt == scan_last) begin
               state_nxt     = IDLE;
               scan_cnt_nxt  = '0;
               out_valid_nxt = 1'b0;
            end else begin
               scan_cnt_nxt = scan_inc;
               out_nxt      = scan_hot;
            end
         end
      end else if (accept) begin
         out_valid_nxt = 1'b1;
         case (mode)
            MODE_ACCUM: begin
               // clear (if requested) has already been folded into mask_nxt
               mask_nxt = mask_nxt | sel_hot;
               out_nxt  = mask_nxt;
            end
            MODE_SCAN: begin
               out_nxt       = OUT_W'(1);
               scan_cnt_nxt  = '0;
               scan_last_nxt = in_sel;
               if (in_sel != '0) state_nxt = SCAN;
            end
            default: out_nxt = sel_hot;
         endcase
      end else if (out_xfer) begin
         out_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         scan_cnt  <= '0;
         scan_last <= '0;
         mask      <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         scan_cnt  <= scan_cnt_nxt;
         scan_last <= scan_last_nxt;
         mask      <= mask_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench for decoder_onehot_seq: queue-based behavioural model compared every cycle,
// plus literal expectations for the documented scenarios.
module tb_decoder_onehot_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, en, clr, in_valid, out_ready;
   logic [1:0] mode;
   logic [2:0] in_sel;
   logic [7:0] out;
   logic       out_valid, in_ready, busy;

   logic        en4, clr4, in_valid4, out_ready4;
   logic [1:0]  mode4;
   logic [3:0]  in_sel4;
   logic [15:0] out4;
   logic        out_valid4, in_ready4, busy4;

   decoder_onehot_seq #(.SEL_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   decoder_onehot_seq #(.SEL_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .mode(mode4), .clr(clr4),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_sel(in_sel4),
      .out(out4), .out_valid(out_valid4), .out_ready(out_ready4), .busy(busy4)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state: the displayed word, its valid, the sticky mask, and the
   // list of scan words still owed (front = word currently on out)
   logic [7:0] m_out, m_mask;
   logic       m_valid;
   logic [7:0] m_seq[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      return rst_n && en && (m_seq.size() == 0) && (!m_valid || out_ready);
   endfunction

   task automatic model_reset();
      m_out = 8'h00; m_mask = 8'h00; m_valid = 1'b0;
      m_seq.delete();
   endtask

   task automatic model_step();
      logic acc, xfer;
      if (!rst_n) begin
         model_reset();
         return;
      end
      acc  = in_valid && model_ready();
      xfer = m_valid && out_ready;
      if (clr) m_mask = 8'h00;
      if (!en) begin
         m_out = 8'h00; m_valid = 1'b0;
         m_seq.delete();
      end else if (m_seq.size() > 0) begin
         if (xfer) begin
            m_seq.delete(0);
            if (m_seq.size() > 0) m_out = m_seq[0];
            else m_valid = 1'b0;
         end
      end else if (acc) begin
         m_valid = 1'b1;
         case (mode)
            2'b01: begin
               m_mask = m_mask | (8'd1 << in_sel);
               m_out  = m_mask;
            end
            2'b10: begin
               m_out = 8'h01;
               if (in_sel != 3'd0)
                  for (int i = 0; i <= int'(in_sel); i++) m_seq.push_back(8'(1 << i));
            end
            default: m_out = 8'd1 << in_sel;
         endcase
      end else if (xfer) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare_all();
      chk("out", {8'h00, out}, {8'h00, m_out});
      chk("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
      chk("busy", {15'd0, busy}, {15'd0, (m_seq.size() > 0)});
      chk("in_ready", {15'd0, in_ready}, {15'd0, model_ready()});
   endtask

   // one clock: model follows the edge, outputs compared on the falling edge,
   // inputs then change 1 ns later
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] m, input logic [2:0] s, input logic r);
      in_valid = v; mode = m; in_sel = s; out_ready = r;
   endtask

   logic [7:0] dec_exp [8];
   logic [7:0] acc_exp [4];
   logic [2:0] acc_sel [4];

   initial begin
      dec_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      acc_exp = '{8'h04, 8'h24, 8'h24, 8'h80};
      acc_sel = '{3'd2, 3'd5, 3'd2, 3'd7};

      rst_n = 1'b0; en = 1'b1; clr = 1'b0;
      drive(1'b0, 2'b00, 3'd0, 1'b1);
      en4 = 1'b1; clr4 = 1'b0; in_valid4 = 1'b0; mode4 = 2'b00; in_sel4 = 4'd0; out_ready4 = 1'b1;
      model_reset();

      cyc();
      cyc();
      chk("rst_out", {8'h00, out}, 16'h0000);
      chk("rst_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_busy", {15'd0, busy}, 16'h0000);
      chk("rst_in_ready", {15'd0, in_ready}, 16'h0000);
      rst_n = 1'b1;

      // DECODE 0..7 back-to-back
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 2'b00, 3'(k), 1'b1);
         cyc();
         chk("decode", {8'h00, out}, {8'h00, dec_exp[k]});
         chk("decode_valid", {15'd0, out_valid}, 16'h0001);
      end
      drive(1'b0, 2'b00, 3'd0, 1'b1);
      cyc();
      chk("decode_drain", {15'd0, out_valid}, 16'h0000);

      // ACCUM 2,5,2 then clr with 7
      for (int i = 0; i < 4; i++) begin
         clr = (i == 3);
         drive(1'b1, 2'b01, acc_sel[i], 1'b1);
         cyc();
         chk("accum", {8'h00, out}, {8'h00, acc_exp[i]});
      end
      clr = 1'b0;
      drive(1'b0, 2'b00, 3'd0, 1'b1);
      cyc();

      // SCAN k=3 with one stall
      drive(1'b1, 2'b10, 3'd3, 1'b1);
      cyc();
      chk("scan3_w0", {8'h00, out}, 16'h0001);
      chk("scan3_busy0", {15'd0, busy}, 16'h0001);
      drive(1'b0, 2'b10, 3'd0, 1'b1);
      cyc();
      chk("scan3_w1", {8'h00, out}, 16'h0002);
      out_ready = 1'b0;
      cyc();
      chk("scan3_stall", {8'h00, out}, 16'h0002);
      chk("scan3_stall_rdy", {15'd0, in_ready}, 16'h0000);
      out_ready = 1'b1;
      cyc();
      chk("scan3_w2", {8'h00, out}, 16'h0004);
      cyc();
      chk("scan3_w3", {8'h00, out}, 16'h0008);
      chk("scan3_busy3", {15'd0, busy}, 16'h0001);
      chk("scan3_rdy3", {15'd0, in_ready}, 16'h0000);
      cyc();
      chk("scan3_done_busy", {15'd0, busy}, 16'h0000);
      chk("scan3_done_valid", {15'd0, out_valid}, 16'h0000);

      // SCAN k=6 aborted by en after the second word
      drive(1'b1, 2'b10, 3'd6, 1'b1);
      cyc();
      drive(1'b0, 2'b10, 3'd0, 1'b1);
      cyc();
      chk("scan6_w1", {8'h00, out}, 16'h0002);
      en = 1'b0;
      cyc();
      chk("abort_out", {8'h00, out}, 16'h0000);
      chk("abort_valid", {15'd0, out_valid}, 16'h0000);
      chk("abort_busy", {15'd0, busy}, 16'h0000);
      en = 1'b1;
      drive(1'b1, 2'b00, 3'd1, 1'b1);
      cyc();
      chk("reen_decode", {8'h00, out}, 16'h0002);
      // mask (0x80) survived the en drop
      drive(1'b1, 2'b01, 3'd0, 1'b1);
      cyc();
      chk("mask_kept", {8'h00, out}, 16'h0081);
      // SCAN k=0 is a single word without busy
      drive(1'b1, 2'b10, 3'd0, 1'b1);
      cyc();
      chk("scan0_out", {8'h00, out}, 16'h0001);
      chk("scan0_busy", {15'd0, busy}, 16'h0000);
      drive(1'b0, 2'b00, 3'd0, 1'b1);
      cyc();
      chk("scan0_drain", {15'd0, out_valid}, 16'h0000);

      // reset in the middle of a stalled scan
      drive(1'b1, 2'b10, 3'd5, 1'b0);
      cyc();
      drive(1'b0, 2'b10, 3'd0, 1'b0);
      cyc();
      chk("stall_hold", {8'h00, out}, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_out", {8'h00, out}, 16'h0000);
      chk("async_valid", {15'd0, out_valid}, 16'h0000);
      chk("async_busy", {15'd0, busy}, 16'h0000);
      chk("async_rdy", {15'd0, in_ready}, 16'h0000);
      cyc();
      rst_n = 1'b1;
      drive(1'b1, 2'b00, 3'd4, 1'b1);
      cyc();
      chk("post_rst_decode", {8'h00, out}, 16'h0010);
      drive(1'b0, 2'b00, 3'd0, 1'b1);
      cyc();

      // SEL_W=4 instance
      in_valid4 = 1'b1; mode4 = 2'b00; in_sel4 = 4'd15;
      cyc();
      chk("w4_decode15", out4, 16'h8000);
      chk("w4_valid", {15'd0, out_valid4}, 16'h0001);
      mode4 = 2'b11; in_sel4 = 4'd9;
      cyc();
      chk("w4_rsvd9", out4, 16'h0200);
      in_valid4 = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
